oculink_link_sequencer: RTL and testbench
=========================================

// Module: oculink_link_sequencer
// PURPOSE
//  Drives OCuLink PERST# and the pcie_top/user_top bring-up handshake in place of the manual VIO reset.
//  Synchronises and debounces card-present, holds PERST# low for a fixed time, then releases it.
//  Waits for user_lnk_up, runs the endpoint configurator (start_config/finished_config/failed_config),
//  and retries on timeout or failure. Sits between oculink_port pins/VIO and the pcie_top + user_top pair.
// PARAMETERS
//  CPRSNT_ACTIVE_LOW    1         1: cprsnt=0 means card present; 0: cprsnt=1 means present
//  DEBOUNCE_CYCLES      250000    consecutive stable synced samples needed to change card state
//  PERST_ASSERT_CYCLES  25000000  perst_n low time per attempt (100 ms @ 250 MHz)
//  LINK_TIMEOUT_CYCLES  25000000  max wait for user_lnk_up after perst_n release
//  CFG_TIMEOUT_CYCLES   2500000   max wait for finished_config/failed_config
//  MAX_RETRIES          3         failed attempts tolerated before FAILED; legal range 1..15
// PORTS
//  user_clk         in   1  sole clock
//  sys_rst_n_c      in   1  synchronous, active-low reset
//  cprsnt           in   1  raw OCuLink card-present pin, asynchronous
//  sw_retrain       in   1  1-cycle request (VIO) to restart bring-up
//  user_lnk_up      in   1  PCIe data-link up from pcie_top
//  finished_config  in   1  configurator success (level)
//  failed_config    in   1  configurator failure (level)
//  perst_n          out  1  PERST# to the device, active low
//  start_config     out  1  configurator start request, level
//  link_ready       out  1  link up and endpoint configured
//  link_failed      out  1  retries exhausted
//  retry_cnt        out  4  failed attempts since last clean start
//  state_dbg        out  4  current FSM state encoding, for VIO probe_in0
// BEHAVIOUR
//  Reset (sys_rst_n_c=0 at a clock edge): state NO_CARD, all counters 0.
//   Outputs after reset: perst_n=0, start_config=0, link_ready=0, link_failed=0, retry_cnt=0.
//  All outputs are registered decodes of state. An output changes on the clock edge that enters the new state.
//  cprsnt path:
//   - 2-FF synchroniser.
//   - Debounce counter: present_db flips only after the synced value differs from present_db
//     for DEBOUNCE_CYCLES consecutive cycles. Any shorter glitch resets the counter.
//  One shared timer. It clears to 0 on every state entry and saturates at its maximum.
//   Timer width = $clog2 of the largest *_CYCLES parameter, plus 1 bit.
//  States:
//  NO_CARD    perst_n=0. present_db=1 -> PERST_HOLD.
//  PERST_HOLD perst_n=0. After PERST_ASSERT_CYCLES cycles in this state -> WAIT_LINK.
//  WAIT_LINK  perst_n=1.
//             - user_lnk_up=1 -> CONFIG.
//             - Timer reaches LINK_TIMEOUT_CYCLES -> RETRY.
//  CONFIG     perst_n=1, start_config=1 (held until the state exits).
//             - failed_config=1 -> RETRY. If finished and failed are both high in the same cycle, failure wins.
//             - Timer reaches CFG_TIMEOUT_CYCLES -> RETRY.
//             - user_lnk_up=0 -> RETRY.
//             - Otherwise, finished_config=1 -> READY.
//  READY      perst_n=1, link_ready=1. user_lnk_up=0 -> RETRY.
//  RETRY      One cycle, perst_n=0. retry_cnt increments and saturates at 15.
//             If the incremented value is >= MAX_RETRIES -> FAILED, else -> PERST_HOLD.
//  FAILED     perst_n=0, link_failed=1. Held until a global override below.
//  Global overrides, in priority order:
//   1. Reset.
//   2. present_db=0 in any state -> NO_CARD; retry_cnt cleared.
//   3. sw_retrain=1 in any state except NO_CARD -> PERST_HOLD; retry_cnt cleared.
//  retry_cnt otherwise clears only on entry to READY.
//  Reset mid-operation: the entire FSM returns to the reset state on that edge.
//   perst_n=0 is guaranteed from the following cycle.
//  Exact timing: card inserted (cprsnt pin valid) at edge 0 -> perst_n rises at edge
//   2 (sync) + DEBOUNCE_CYCLES + 1 (FSM) + PERST_ASSERT_CYCLES.
// TESTING (DEBOUNCE=4, PERST_ASSERT=10, LINK_TIMEOUT=50, CFG_TIMEOUT=20, MAX_RETRIES=2)
//  1. Reset, cprsnt held absent 1000 cycles -> perst_n=0, state_dbg=NO_CARD, no other output ever asserts.
//  2. Insert card, 3-cycle glitch, then stable -> glitch ignored; perst_n rises exactly 17 cycles after stable.
//  3. user_lnk_up never asserts -> RETRY twice: perst_n low 11 cycles between attempts,
//     then link_failed=1 and retry_cnt=2. sw_retrain -> retry_cnt=0 and perst_n=0 for 10 cycles.
//  4. user_lnk_up 5 cycles after perst_n release; finished_config 3 cycles later ->
//     start_config high for 4 cycles, link_ready=1 on the next edge, retry_cnt=0.
//  5. In CONFIG, finished_config and failed_config high together -> RETRY (retry_cnt=1), link_ready stays 0.
//  6. In READY, remove card for 4+ cycles -> NO_CARD, perst_n=0, link_ready=0.
//     Separately, drop user_lnk_up in READY -> one RETRY cycle, then a new PERST_HOLD.

Source files
------------

// File: rtl/oculink_link_sequencer.sv
// OCuLink bring-up sequencer: debounced card detect, PERST# timing, link/config handshake with retries.
// Outputs are registered decodes of the next state; no backpressure, inputs are sampled every cycle.
module oculink_link_sequencer #(
  parameter int CPRSNT_ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int PERST_ASSERT_CYCLES = 25000000,
  parameter int LINK_TIMEOUT_CYCLES = 25000000,
  parameter int CFG_TIMEOUT_CYCLES  = 2500000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       i_user_clk,
  input  logic       i_sys_rst_n_c,
  input  logic       i_cprsnt,
  input  logic       i_sw_retrain,
  input  logic       i_user_lnk_up,
  input  logic       i_finished_config,
  input  logic       i_failed_config,
  output logic       o_perst_n,
  output logic       o_start_config,
  output logic       o_link_ready,
  output logic       o_link_failed,
  output logic [3:0] o_retry_cnt,
  output logic [3:0] o_state_dbg
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > PERST_ASSERT_CYCLES) ? DEBOUNCE_CYCLES : PERST_ASSERT_CYCLES;
  localparam int MAX_CD = (LINK_TIMEOUT_CYCLES > CFG_TIMEOUT_CYCLES) ? LINK_TIMEOUT_CYCLES : CFG_TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAX_C) + 1;
  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0]  TMAX       = '1;
  localparam logic [TW-1:0]  PERST_LAST = TW'(PERST_ASSERT_CYCLES - 1);
  localparam logic [TW-1:0]  LINK_TO    = TW'(LINK_TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  CFG_TO     = TW'(CFG_TIMEOUT_CYCLES);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     MAX_R      = 4'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_NO_CARD    = 4'd0,
    S_PERST_HOLD = 4'd1,
    S_WAIT_LINK  = 4'd2,
    S_CONFIG     = 4'd3,
    S_READY      = 4'd4,
    S_RETRY      = 4'd5,
    S_FAILED     = 4'd6
  } state_t;

  logic           w_present_raw;
  logic           r_present_s1;
  logic           r_present_s2;
  logic           r_present_db;
  logic [DBW-1:0] r_db_cnt;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_restart;
  logic           w_entry;
  logic [TW-1:0]  r_timer;
  logic [3:0]     r_retry_cnt;
  logic [3:0]     w_retry_nxt;
  logic           r_perst_n;
  logic           r_start_config;
  logic           r_link_ready;
  logic           r_link_failed;

  // Polarity is normalised before the synchroniser so reset means "absent".
  assign w_present_raw = (CPRSNT_ACTIVE_LOW != 0) ? ~i_cprsnt : i_cprsnt;

  always_ff @(posedge i_user_clk) begin
    if (!i_sys_rst_n_c) begin
      r_present_s1 <= 1'b0;
      r_present_s2 <= 1'b0;
      r_present_db <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_present_s1 <= w_present_raw;
      r_present_s2 <= r_present_s1;
      if (r_present_s2 != r_present_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_present_db <= r_present_s2;
          r_db_cnt     <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_cnt;
    w_restart   = 1'b0;
    case (r_state)
      S_NO_CARD:    if (r_present_db) w_state_nxt = S_PERST_HOLD;
      S_PERST_HOLD: if (r_timer >= PERST_LAST) w_state_nxt = S_WAIT_LINK;
      S_WAIT_LINK: begin
        if (i_user_lnk_up)          w_state_nxt = S_CONFIG;
        else if (r_timer >= LINK_TO) w_state_nxt = S_RETRY;
      end
      S_CONFIG: begin
        // Failure, timeout and link loss all outrank a simultaneous finish.
        if (i_failed_config || (r_timer >= CFG_TO) || !i_user_lnk_up) w_state_nxt = S_RETRY;
        else if (i_finished_config)                                    w_state_nxt = S_READY;
      end
      S_READY:  if (!i_user_lnk_up) w_state_nxt = S_RETRY;
      S_RETRY:  w_state_nxt = (r_retry_cnt >= MAX_R) ? S_FAILED : S_PERST_HOLD;
      S_FAILED: w_state_nxt = S_FAILED;
      default:  w_state_nxt = S_NO_CARD;
    endcase

    if ((w_state_nxt == S_RETRY) && (r_state != S_RETRY))
      w_retry_nxt = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;
    if ((w_state_nxt == S_READY) && (r_state != S_READY))
      w_retry_nxt = 4'd0;

    if (!r_present_db) begin
      w_state_nxt = S_NO_CARD;
      w_retry_nxt = 4'd0;
    end else if (i_sw_retrain && (r_state != S_NO_CARD)) begin
      w_state_nxt = S_PERST_HOLD;
      w_retry_nxt = 4'd0;
      w_restart   = 1'b1;
    end
  end

  // A retrain while already holding PERST# counts as a fresh entry and restarts the hold.
  assign w_entry = (w_state_nxt != r_state) || w_restart;

  always_ff @(posedge i_user_clk) begin
    if (!i_sys_rst_n_c) begin
      r_state        <= S_NO_CARD;
      r_timer        <= '0;
      r_retry_cnt    <= 4'd0;
      r_perst_n      <= 1'b0;
      r_start_config <= 1'b0;
      r_link_ready   <= 1'b0;
      r_link_failed  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_entry ? '0 : ((r_timer == TMAX) ? r_timer : r_timer + TW'(1));
      r_retry_cnt    <= w_retry_nxt;
      r_perst_n      <= (w_state_nxt == S_WAIT_LINK) || (w_state_nxt == S_CONFIG) ||
                        (w_state_nxt == S_READY);
      r_start_config <= (w_state_nxt == S_CONFIG);
      r_link_ready   <= (w_state_nxt == S_READY);
      r_link_failed  <= (w_state_nxt == S_FAILED);
    end
  end

  assign o_perst_n      = r_perst_n;
  assign o_start_config = r_start_config;
  assign o_link_ready   = r_link_ready;
  assign o_link_failed  = r_link_failed;
  assign o_retry_cnt    = r_retry_cnt;
  assign o_state_dbg    = r_state;

endmodule

// File: tb/tb_oculink_link_sequencer.sv
// Bench for oculink_link_sequencer: expected output transitions (edge, value) are queued from
// timing arithmetic on the randomized stimulus; a monitor pops one entry per observed output change.
module tb_oculink_link_sequencer;

  localparam int DB = 4;
  localparam int PA = 10;
  localparam int LT = 50;
  localparam int CT = 20;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cprsnt = 1'b1;
  logic       sw_retrain = 1'b0;
  logic       lnk = 1'b0;
  logic       fin = 1'b0;
  logic       fail = 1'b0;
  logic       perst_n;
  logic       start_config;
  logic       link_ready;
  logic       link_failed;
  logic [3:0] retry_cnt;
  logic [3:0] state_dbg;

  oculink_link_sequencer #(
    .CPRSNT_ACTIVE_LOW  (1),
    .DEBOUNCE_CYCLES    (DB),
    .PERST_ASSERT_CYCLES(PA),
    .LINK_TIMEOUT_CYCLES(LT),
    .CFG_TIMEOUT_CYCLES (CT),
    .MAX_RETRIES        (MR)
  ) dut (
    .i_user_clk       (clk),
    .i_sys_rst_n_c    (rst_n),
    .i_cprsnt         (cprsnt),
    .i_sw_retrain     (sw_retrain),
    .i_user_lnk_up    (lnk),
    .i_finished_config(fin),
    .i_failed_config  (fail),
    .o_perst_n        (perst_n),
    .o_start_config   (start_config),
    .o_link_ready     (link_ready),
    .o_link_failed    (link_failed),
    .o_retry_cnt      (retry_cnt),
    .o_state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         e;
    logic [7:0] v;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;
  bit  primed = 1'b0;
  logic [7:0] prev;

  // Expected output vector {perst_n, start_config, link_ready, link_failed, retry_cnt} from edge e on.
  task automatic expect_ev(input int e, input bit p, input bit s, input bit r, input bit f, input int rc);
    ev_t x;
    x.e = e;
    x.v = {p, s, r, f, 4'(rc)};
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic tick_to(input int x);
    while (edge_n < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] cur;
    ev_t        x;
    if (mon_en) begin
      cur = {perst_n, start_config, link_ready, link_failed, retry_cnt};
      if (!primed) begin
        primed = 1'b1;
        prev   = cur;
      end else if (cur !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: edge %0d outputs %h, no change expected", edge_n, cur);
        end else begin
          x = exp_q.pop_front();
          if ((x.e != edge_n) || (x.v !== cur)) begin
            fails++;
            $display("FAIL transition: edge %0d outputs %h, expected edge %0d outputs %h",
                     edge_n, cur, x.e, x.v);
          end
        end
        prev = cur;
      end
    end
  end

  // Link comes up d cycles into WAIT_LINK, configurator finishes f cycles into CONFIG.
  task automatic bring_up(input int w, input int rc);
    int d, f, c;
    d = $urandom_range(0, 8);
    f = $urandom_range(0, 10);
    tick_to(w + d);
    lnk = 1'b1;
    c = w + d + 1;
    expect_ev(c, 1, 1, 0, 0, rc);
    tick_to(c + f);
    fin = 1'b1;
    expect_ev(c + f + 1, 1, 0, 1, 0, 0);
    tick_to(c + f + 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expected transitions pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   g, gap, e, w, p, r1, r2, fe, c, k, rr, q0, q;
    ev_t  x;

    tick_to(3);
    rst_n = 1'b1;
    chk("reset_perst_n", int'(perst_n), 0);
    chk("reset_start_config", int'(start_config), 0);
    chk("reset_link_ready", int'(link_ready), 0);
    chk("reset_link_failed", int'(link_failed), 0);
    chk("reset_retry_cnt", int'(retry_cnt), 0);
    chk("reset_state_dbg", int'(state_dbg), 0);
    mon_en = 1'b1;

    // Card absent for a long time: nothing may move.
    tick_to(edge_n + 1000);
    chk("absent_perst_n", int'(perst_n), 0);
    chk("absent_state_dbg", int'(state_dbg), 0);

    // Insertion preceded by a glitch shorter than the debounce window.
    g   = $urandom_range(1, DB - 1);
    gap = $urandom_range(1, 5);
    e   = edge_n;
    cprsnt = 1'b0;
    tick_to(e + g);
    cprsnt = 1'b1;
    tick_to(e + g + gap);
    e = edge_n;
    cprsnt = 1'b0;
    w = e + 2 + DB + 1 + PA;
    expect_ev(w, 1, 0, 0, 0, 0);
    tick_to(w);

    // Link never comes up: two timeouts, then FAILED.
    p  = w;
    r1 = p + LT + 1;
    w  = r1 + 1 + PA;
    r2 = w + LT + 1;
    fe = r2 + 1;
    expect_ev(r1, 0, 0, 0, 0, 1);
    expect_ev(w,  1, 0, 0, 0, 1);
    expect_ev(r2, 0, 0, 0, 0, 2);
    expect_ev(fe, 0, 0, 0, 1, 2);
    tick_to(fe + $urandom_range(1, 20));
    chk("failed_retry_cnt", int'(retry_cnt), MR);

    // Software retrain out of FAILED.
    e = edge_n;
    sw_retrain = 1'b1;
    expect_ev(e + 1, 0, 0, 0, 0, 0);
    expect_ev(e + 1 + PA, 1, 0, 0, 0, 0);
    tick_to(e + 1);
    sw_retrain = 1'b0;
    w = e + 1 + PA;
    tick_to(w);

    // Finished and failed together in CONFIG: failure wins.
    tick_to(w + $urandom_range(0, 8));
    lnk = 1'b1;
    c = edge_n + 1;
    expect_ev(c, 1, 1, 0, 0, 0);
    k = $urandom_range(0, 5);
    tick_to(c + k);
    fin  = 1'b1;
    fail = 1'b1;
    rr = c + k + 1;
    expect_ev(rr, 0, 0, 0, 0, 1);
    tick_to(rr);
    fin  = 1'b0;
    fail = 1'b0;
    lnk  = 1'b0;
    w = rr + 1 + PA;
    expect_ev(w, 1, 0, 0, 0, 1);
    tick_to(w);

    // Successful bring-up clears the retry count on READY.
    bring_up(w, 1);
    tick_to(edge_n + $urandom_range(1, 10));

    // Link drop in READY: one RETRY cycle, new PERST# hold, then recover.
    e = edge_n;
    lnk = 1'b0;
    fin = 1'b0;
    expect_ev(e + 1, 0, 0, 0, 0, 1);
    w = e + 2 + PA;
    expect_ev(w, 1, 0, 0, 0, 1);
    tick_to(w);
    bring_up(w, 1);
    tick_to(edge_n + $urandom_range(1, 10));

    // Removal glitch of DB-1 cycles is ignored, a stable removal returns to NO_CARD.
    e = edge_n;
    cprsnt = 1'b1;
    tick_to(e + DB - 1);
    cprsnt = 1'b0;
    tick_to(edge_n + 5);
    e = edge_n;
    cprsnt = 1'b1;
    expect_ev(e + 2 + DB + 1, 0, 0, 0, 0, 0);
    tick_to(e + 2 + DB + 1 + 3);
    lnk = 1'b0;
    fin = 1'b0;

    // Retrain is ignored without a card.
    sw_retrain = 1'b1;
    tick_to(edge_n + 1);
    sw_retrain = 1'b0;
    tick_to(edge_n + 20);
    chk("nocard_retrain_state_dbg", int'(state_dbg), 0);

    // Reset in the middle of WAIT_LINK, then re-acquire the card.
    e = edge_n;
    cprsnt = 1'b0;
    w = e + 2 + DB + 1 + PA;
    expect_ev(w, 1, 0, 0, 0, 0);
    tick_to(w + $urandom_range(1, 5));
    q0 = edge_n;
    rst_n = 1'b0;
    expect_ev(q0 + 1, 0, 0, 0, 0, 0);
    tick_to(q0 + 2);
    rst_n = 1'b1;
    q = q0 + 2;
    expect_ev(q + 2 + DB + 1 + PA, 1, 0, 0, 0, 0);
    tick_to(q + 2 + DB + 1 + PA + 10);

    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_transition: expected edge %0d outputs %h never observed", x.e, x.v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
